ddaeval_readout_arbiter: RTL and testbench

Shares the single block-history / lock / readout / free resource chain between NREQ trigger handlers, e.g. the soft-trigger handler and RF-trigger handlers. A requester wins ownership on its history request and keeps the whole chain until the downstream free acknowledge completes its transaction. Ownership is granted round-robin. A watchdog reclaims the chain from a stalled owner. The block sits between the trigger handlers and the history buffer, lock manager, readout and free logic.

---
 rtl/ddaeval_readout_arbiter.sv | 153 +++++++++++++++
 tb/tb_ddaeval_readout_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddaeval_readout_arbiter.sv
// Round-robin owner arbitration for the shared history/lock/readout/free chain.
// One requester owns the whole chain from its history grant until free_ack_i or watchdog expiry.

module ddaeval_readout_lane (
    input  logic       sel,
    input  logic [3:0] acks,
    output logic [3:0] routed
);
    assign routed = sel ? acks : 4'b0000;
endmodule

module ddaeval_readout_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 65535
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    // requester side
    input  logic [NREQ-1:0]       history_req_i,
    input  logic [NREQ-1:0][8:0]  nprev_i,
    output logic [NREQ-1:0]       history_ack_o,
    output logic [9:0]            block_o,
    input  logic [NREQ-1:0][8:0]  lock_address_i,
    input  logic [NREQ-1:0]       lock_strobe_i,
    input  logic [NREQ-1:0]       lock_i,
    output logic [NREQ-1:0]       lock_ack_o,
    input  logic [NREQ-1:0][8:0]  free_address_i,
    input  logic [NREQ-1:0]       free_strobe_i,
    output logic [NREQ-1:0]       free_ack_o,
    input  logic [NREQ-1:0][10:0] read_address_i,
    input  logic [NREQ-1:0]       read_strobe_i,
    input  logic [NREQ-1:0][31:0] event_id_i,
    output logic [NREQ-1:0]       read_done_o,
    // downstream side
    output logic                  history_req_o,
    input  logic                  history_ack_i,
    output logic [8:0]            nprev_o,
    input  logic [9:0]            block_i,
    output logic [8:0]            lock_address_o,
    output logic                  lock_strobe_o,
    output logic                  lock_o,
    input  logic                  lock_ack_i,
    output logic [8:0]            free_address_o,
    output logic                  free_strobe_o,
    input  logic                  free_ack_i,
    output logic [10:0]           read_address_o,
    output logic                  read_strobe_o,
    output logic [31:0]           event_id_o,
    input  logic                  read_done_i,
    // status
    output logic [2:0]            owner_o,
    output logic                  busy_o,
    output logic                  timeout_o,
    output logic [15:0]           timeout_count_o
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   owner, last, pick, idx;
    logic            pick_vld;
    logic            held;
    logic [15:0]     wd;
    logic            grant, expire, release_chain;
    logic [NREQ-1:0][3:0] lane_ack;

    assign grant         = (state == GRANT);
    // free_ack_i wins over expiry in the same cycle: normal completion, no timeout
    assign expire        = grant && !free_ack_i && (wd == 16'(TIMEOUT - 1));
    assign release_chain = grant && (free_ack_i || (wd == 16'(TIMEOUT - 1)));

    // search starts just after the last owner, so a repeat requester goes to the back
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IW'((int'(last) + i) % NREQ);
            if (!pick_vld && history_req_i[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = GRANT;
            GRANT:   if (release_chain) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            owner           <= '0;
            last            <= IW'(NREQ - 1);
            held            <= 1'b0;
            wd              <= '0;
            timeout_o       <= 1'b0;
            timeout_count_o <= '0;
        end else begin
            timeout_o <= expire;
            if (!grant && pick_vld) begin
                owner <= pick;
                held  <= 1'b1;
                wd    <= '0;
            end else if (grant) begin
                wd <= wd + 16'd1;
            end
            if (release_chain) last <= owner;
            if (expire && timeout_count_o != 16'hFFFF)
                timeout_count_o <= timeout_count_o + 16'd1;
        end
    end

    // strobes are gated by ownership; address/data keep showing the last owner
    // once anyone has been granted, and read 0 until then
    assign history_req_o  = grant & history_req_i[owner];
    assign lock_strobe_o  = grant & lock_strobe_i[owner];
    assign free_strobe_o  = grant & free_strobe_i[owner];
    assign read_strobe_o  = grant & read_strobe_i[owner];
    assign nprev_o        = held ? nprev_i[owner]        : 9'd0;
    assign lock_address_o = held ? lock_address_i[owner] : 9'd0;
    assign lock_o         = held & lock_i[owner];
    assign free_address_o = held ? free_address_i[owner] : 9'd0;
    assign read_address_o = held ? read_address_i[owner] : 11'd0;
    assign event_id_o     = held ? event_id_i[owner]     : 32'd0;
    assign block_o        = block_i;

    assign busy_o  = grant;
    assign owner_o = grant ? 3'(owner) : 3'd0;

    for (genvar k = 0; k < NREQ; k++) begin : g_lane
        ddaeval_readout_lane u_lane (
            .sel    (grant && (owner == IW'(k))),
            .acks   ({read_done_i, free_ack_i, lock_ack_i, history_ack_i}),
            .routed (lane_ack[k])
        );
        assign history_ack_o[k] = lane_ack[k][0];
        assign lock_ack_o[k]    = lane_ack[k][1];
        assign free_ack_o[k]    = lane_ack[k][2];
        assign read_done_o[k]   = lane_ack[k][3];
    end

endmodule

// File: tb/tb_ddaeval_readout_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level ownership model.
module tb_ddaeval_readout_arbiter;
    localparam int NREQ    = 3;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]       history_req, lock_strobe, lock_v, free_strobe, read_strobe;
    logic [NREQ-1:0][8:0]  nprev, lock_address, free_address;
    logic [NREQ-1:0][10:0] read_address;
    logic [NREQ-1:0][31:0] event_id;
    logic                  ds_hack, ds_lack, ds_fack, ds_rdone;
    logic [9:0]            ds_block;

    logic [NREQ-1:0] history_ack_o, lock_ack_o, free_ack_o, read_done_o;
    logic [9:0]      block_o;
    logic            history_req_o, lock_strobe_o, lock_o, free_strobe_o, read_strobe_o;
    logic [8:0]      nprev_o, lock_address_o, free_address_o;
    logic [10:0]     read_address_o;
    logic [31:0]     event_id_o;
    logic [2:0]      owner_o;
    logic            busy_o, timeout_o;
    logic [15:0]     timeout_count_o;

    ddaeval_readout_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .history_req_i(history_req), .nprev_i(nprev), .history_ack_o(history_ack_o),
        .block_o(block_o),
        .lock_address_i(lock_address), .lock_strobe_i(lock_strobe), .lock_i(lock_v),
        .lock_ack_o(lock_ack_o),
        .free_address_i(free_address), .free_strobe_i(free_strobe), .free_ack_o(free_ack_o),
        .read_address_i(read_address), .read_strobe_i(read_strobe), .event_id_i(event_id),
        .read_done_o(read_done_o),
        .history_req_o(history_req_o), .history_ack_i(ds_hack), .nprev_o(nprev_o),
        .block_i(ds_block),
        .lock_address_o(lock_address_o), .lock_strobe_o(lock_strobe_o), .lock_o(lock_o),
        .lock_ack_i(ds_lack),
        .free_address_o(free_address_o), .free_strobe_o(free_strobe_o), .free_ack_i(ds_fack),
        .read_address_o(read_address_o), .read_strobe_o(read_strobe_o),
        .event_id_o(event_id_o), .read_done_i(ds_rdone),
        .owner_o(owner_o), .busy_o(busy_o), .timeout_o(timeout_o),
        .timeout_count_o(timeout_count_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference model: who owns the chain, how long it has held it, timeout bookkeeping
    bit m_busy, m_valid, m_tpulse;
    int m_owner, m_last, m_age, m_tcnt;
    logic [NREQ-1:0] hack_seen;

    task automatic model_reset();
        m_busy = 0; m_valid = 0; m_tpulse = 0;
        m_owner = 0; m_last = NREQ - 1; m_age = 0; m_tcnt = 0;
    endtask

    function automatic logic [NREQ-1:0] to_owner(input logic v);
        logic [NREQ-1:0] one;
        one = NREQ'(1);
        return v ? (one << m_owner) : '0;
    endfunction

    task automatic check_all();
        chk("busy",  busy_o, 64'(m_busy));
        chk("owner", owner_o, m_busy ? 64'(m_owner) : 64'd0);
        chk("hreq",  history_req_o, 64'(m_busy & history_req[m_owner]));
        chk("hack",  history_ack_o, to_owner(m_busy & ds_hack));
        chk("lstb",  lock_strobe_o, 64'(m_busy & lock_strobe[m_owner]));
        chk("lack",  lock_ack_o, to_owner(m_busy & ds_lack));
        chk("fstb",  free_strobe_o, 64'(m_busy & free_strobe[m_owner]));
        chk("fack",  free_ack_o, to_owner(m_busy & ds_fack));
        chk("rstb",  read_strobe_o, 64'(m_busy & read_strobe[m_owner]));
        chk("rdone", read_done_o, to_owner(m_busy & ds_rdone));
        chk("nprev", nprev_o, m_valid ? 64'(nprev[m_owner]) : 64'd0);
        chk("lock",  {lock_o, lock_address_o},
            m_valid ? 64'({lock_v[m_owner], lock_address[m_owner]}) : 64'd0);
        chk("faddr", free_address_o, m_valid ? 64'(free_address[m_owner]) : 64'd0);
        chk("raddr", read_address_o, m_valid ? 64'(read_address[m_owner]) : 64'd0);
        chk("evid",  event_id_o, m_valid ? 64'(event_id[m_owner]) : 64'd0);
        chk("block", block_o, ds_block);
        chk("tpulse", timeout_o, 64'(m_tpulse));
        chk("tcnt",  timeout_count_o, 64'(m_tcnt));
        hack_seen = to_owner(m_busy & ds_hack);
    endtask

    task automatic advance();
        m_tpulse = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_busy) begin
            if (ds_fack) begin
                m_busy = 0; m_last = m_owner;
            end else if (m_age == TIMEOUT - 1) begin
                m_busy = 0; m_last = m_owner; m_tpulse = 1;
                if (m_tcnt < 65535) m_tcnt++;
            end else begin
                m_age++;
            end
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                int j = (m_last + k) % NREQ;
                if (history_req[j]) begin
                    m_busy = 1; m_owner = j; m_valid = 1; m_age = 0;
                    break;
                end
            end
        end
    endtask

    // called at a negedge with inputs already set; returns at the next negedge
    task automatic tick();
        #1;
        check_all();
        advance();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        history_req = '0; lock_strobe = '0; lock_v = '0; free_strobe = '0; read_strobe = '0;
        nprev = '0; lock_address = '0; free_address = '0; read_address = '0; event_id = '0;
        ds_hack = 0; ds_lack = 0; ds_fack = 0; ds_rdone = 0; ds_block = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        model_reset();
        tick();
        tick();
        rst_n = 1;
    endtask

    int n0, pulses;
    bit seen1;

    initial begin
        clear_inputs();
        model_reset();
        hack_seen = '0;
        @(negedge clk);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_owner", owner_o, 0);
        chk("rst_tcnt", timeout_count_o, 0);
        chk("rst_nprev", nprev_o, 0);
        tick();
        rst_n = 1;

        // single requester full transaction
        history_req[0] = 1; nprev[0] = 9'd2; ds_block = 10'h155;
        tick();
        #1;
        chk("t1_busy", busy_o, 1);
        chk("t1_nprev", nprev_o, 2);
        chk("t1_block", block_o, 10'h155);
        ds_hack = 1;
        #1 chk("t1_hack", history_ack_o, 3'b001);
        tick();
        history_req[0] = 0; ds_hack = 0;
        lock_strobe[0] = 1; lock_v[0] = 1; lock_address[0] = 9'h0a5; ds_lack = 1;
        #1;
        chk("t1_lstb", lock_strobe_o, 1);
        chk("t1_lack", lock_ack_o, 3'b001);
        tick();
        lock_strobe[0] = 0; ds_lack = 0;
        read_strobe[0] = 1; read_address[0] = 11'h123; event_id[0] = 32'hdeadbeef; ds_rdone = 1;
        #1;
        chk("t1_evid", event_id_o, 32'hdeadbeef);
        chk("t1_rdone", read_done_o, 3'b001);
        tick();
        read_strobe[0] = 0; ds_rdone = 0;
        lock_strobe[0] = 1; lock_v[0] = 0; ds_lack = 1;
        tick();
        lock_strobe[0] = 0; ds_lack = 0;
        free_strobe[0] = 1; free_address[0] = 9'h0a5; ds_fack = 1;
        #1 chk("t1_fack", free_ack_o, 3'b001);
        tick();
        free_strobe[0] = 0; ds_fack = 0;
        #1;
        chk("t1_busy_fall", busy_o, 0);
        chk("t1_addr_hold", free_address_o, 9'h0a5);
        tick();

        // simultaneous requests, round-robin order
        do_reset();
        history_req[0] = 1; history_req[1] = 1;
        tick();
        #1 chk("rr_first", owner_o, 0);
        ds_hack = 1;
        tick();
        history_req[0] = 0; ds_hack = 0; ds_fack = 1;
        tick();
        ds_fack = 0; history_req[0] = 1;
        tick();
        #1 chk("rr_second", owner_o, 1);
        ds_hack = 1;
        tick();
        history_req[1] = 0; ds_hack = 0; ds_fack = 1;
        tick();
        ds_fack = 0;
        tick();
        #1;
        chk("rr_third", owner_o, 0);
        chk("rr_third_busy", busy_o, 1);
        tick();

        // non-owner strobe ignored
        do_reset();
        history_req[0] = 1;
        tick();
        lock_strobe[1] = 1; ds_lack = 1;
        #1;
        chk("ns_lstb", lock_strobe_o, 0);
        chk("ns_lack1", lock_ack_o[1], 0);
        tick();

        // watchdog expiry with a pending requester
        do_reset();
        history_req[0] = 1; history_req[1] = 1;
        n0 = 0; pulses = 0; seen1 = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (busy_o && owner_o == 3'd0) n0++;
            if (timeout_o) pulses++;
            if (busy_o && owner_o == 3'd1) seen1 = 1;
            tick();
        end
        #1;
        chk("to_grant_cycles", n0, 16);
        chk("to_pulses", pulses, 1);
        chk("to_count", timeout_count_o, 1);
        chk("to_next_owner", seen1, 1);

        // free_ack on the expiry cycle counts as completion
        do_reset();
        history_req[0] = 1;
        tick();
        repeat (15) tick();
        ds_fack = 1;
        #1 chk("fx_fack", free_ack_o, 3'b001);
        tick();
        ds_fack = 0; history_req = '0;
        #1;
        chk("fx_no_pulse", timeout_o, 0);
        chk("fx_cnt", timeout_count_o, 0);
        chk("fx_idle", busy_o, 0);
        tick();

        // asynchronous reset mid-read
        do_reset();
        history_req[0] = 1;
        tick();
        read_strobe[0] = 1; read_address[0] = 11'h3c7; event_id[0] = 32'h12345678;
        #1 chk("ar_pre_stb", read_strobe_o, 1);
        #1 rst_n = 0;
        model_reset();
        #1;
        chk("ar_stb", read_strobe_o, 0);
        chk("ar_busy", busy_o, 0);
        chk("ar_raddr", read_address_o, 0);
        chk("ar_evid", event_id_o, 0);
        @(negedge clk);
        clear_inputs();
        tick();
        tick();
        rst_n = 1;
        history_req = 3'b111;
        tick();
        #1;
        chk("ar_prio_owner", owner_o, 0);
        chk("ar_prio_busy", busy_o, 1);
        tick();

        // random traffic against the model
        do_reset();
        hack_seen = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (history_req[k]) begin
                    if (hack_seen[k] && $urandom_range(0, 1) == 1) history_req[k] = 0;
                end else begin
                    history_req[k] = ($urandom_range(0, 3) == 0);
                end
                nprev[k]        = 9'($urandom);
                lock_address[k] = 9'($urandom);
                free_address[k] = 9'($urandom);
                read_address[k] = 11'($urandom);
                event_id[k]     = $urandom;
                lock_strobe[k]  = 1'($urandom);
                lock_v[k]       = 1'($urandom);
                free_strobe[k]  = 1'($urandom);
                read_strobe[k]  = 1'($urandom);
            end
            ds_hack  = ($urandom_range(0, 2) == 0);
            ds_lack  = 1'($urandom);
            ds_rdone = 1'($urandom);
            ds_fack  = ($urandom_range(0, 11) == 0);
            ds_block = 10'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
